// File: rtl/inst_s_decoder_if.sv
// -----------------------------------------------------------------------------
// inst_s_decoder_if
// Bundle between the fetch side and the S-type field decoder.
//   master : drives in_valid / instruction_word and observes the decoded fields
//   slave  : the decoder; it samples the instruction and drives the registered
//            fields, the sign-extended offset, the store width and the flags
// XLEN sets the width of the sign-extended store offset (imm_s).
// -----------------------------------------------------------------------------
interface inst_s_decoder_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [31:0]     instruction_word;
  logic            out_valid;
  logic [6:0]      imm_S_MSB;
  logic [4:0]      rs2;
  logic [4:0]      rs1;
  logic [4:0]      imm_S_LSB;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_s;
  logic [1:0]      store_size;
  logic            is_store;
  logic            illegal;

  modport master (
    output in_valid, instruction_word,
    input  out_valid, imm_S_MSB, rs2, rs1, imm_S_LSB, funct3,
           imm_s, store_size, is_store, illegal
  );

  modport slave (
    input  in_valid, instruction_word,
    output out_valid, imm_S_MSB, rs2, rs1, imm_S_LSB, funct3,
           imm_s, store_size, is_store, illegal
  );
endinterface

// File: rtl/inst_s_decoder.sv
// -----------------------------------------------------------------------------
// inst_s_decoder
// Registered decoder for RISC-V S-type (store) instructions, one cycle latency,
// one instruction per cycle, no backpressure.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (outputs to 0, store_size to 2'b11)
//   bus  : inst_s_decoder_if.slave
//          in:  in_valid, instruction_word
//          out: out_valid, imm_S_MSB, rs2, rs1, imm_S_LSB, funct3, imm_s,
//               store_size, is_store, illegal
// Field outputs load on every valid instruction whatever its opcode, and hold
// while in_valid is low; the qualification flags and out_valid follow in_valid.
// -----------------------------------------------------------------------------
module inst_s_decoder #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  inst_s_decoder_if.slave bus
);

  localparam logic [6:0] OPC_STORE = 7'b0100011;

  logic [31:0]     instr;
  logic            store_comb;

  logic            out_valid_q,  out_valid_d;
  logic [6:0]      imm_msb_q,    imm_msb_d;
  logic [4:0]      rs2_q,        rs2_d;
  logic [4:0]      rs1_q,        rs1_d;
  logic [4:0]      imm_lsb_q,    imm_lsb_d;
  logic [2:0]      funct3_q,     funct3_d;
  logic [XLEN-1:0] imm_s_q,      imm_s_d;
  logic [1:0]      store_size_q, store_size_d;
  logic            is_store_q,   is_store_d;
  logic            illegal_q,    illegal_d;

  assign instr = bus.instruction_word;

  // Legal store widths are SB/SH/SW only: funct3 000, 001, 010.
  assign store_comb = (instr[6:0] == OPC_STORE) && !instr[14] &&
                      (instr[13:12] != 2'b11);

  always_comb begin
    imm_msb_d = imm_msb_q;
    rs2_d     = rs2_q;
    rs1_d     = rs1_q;
    imm_lsb_d = imm_lsb_q;
    funct3_d  = funct3_q;
    imm_s_d   = imm_s_q;
    if (bus.in_valid) begin
      imm_msb_d = instr[31:25];
      rs2_d     = instr[24:20];
      rs1_d     = instr[19:15];
      imm_lsb_d = instr[11:7];
      funct3_d  = instr[14:12];
      imm_s_d   = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    end
    out_valid_d  = bus.in_valid;
    is_store_d   = bus.in_valid & store_comb;
    illegal_d    = bus.in_valid & ~store_comb;
    // "none" encoding whenever the captured word is not a legal store,
    // including idle cycles.
    store_size_d = is_store_d ? instr[13:12] : 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      imm_msb_q    <= '0;
      rs2_q        <= '0;
      rs1_q        <= '0;
      imm_lsb_q    <= '0;
      funct3_q     <= '0;
      imm_s_q      <= '0;
      store_size_q <= 2'b11;
      is_store_q   <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      imm_msb_q    <= imm_msb_d;
      rs2_q        <= rs2_d;
      rs1_q        <= rs1_d;
      imm_lsb_q    <= imm_lsb_d;
      funct3_q     <= funct3_d;
      imm_s_q      <= imm_s_d;
      store_size_q <= store_size_d;
      is_store_q   <= is_store_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.imm_S_MSB  = imm_msb_q;
  assign bus.rs2        = rs2_q;
  assign bus.rs1        = rs1_q;
  assign bus.imm_S_LSB  = imm_lsb_q;
  assign bus.funct3     = funct3_q;
  assign bus.imm_s      = imm_s_q;
  assign bus.store_size = store_size_q;
  assign bus.is_store   = is_store_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_inst_s_decoder.sv
// -----------------------------------------------------------------------------
// tb_inst_s_decoder
// Directed vectors for inst_s_decoder. The driver applies one vector per clock
// (on the falling edge) and queues the hand-computed outputs expected after the
// next rising edge; the monitor pops one entry per rising edge and compares
// every output field.
// -----------------------------------------------------------------------------
module tb_inst_s_decoder;

  localparam int XLEN = 32;

  typedef struct {
    string       name;
    logic        v;
    logic [6:0]  msb;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [4:0]  lsb;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [1:0]  size;
    logic        st;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   driver_done = 1'b0;
  exp_t exp_q[$];

  inst_s_decoder_if #(.XLEN(XLEN)) bus ();

  inst_s_decoder #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string vec, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s actual=0x%08h required=0x%08h", vec, field, act, req);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] w,
                      input exp_t e);
    @(negedge clk);
    rst                  = r;
    bus.in_valid         = v;
    bus.instruction_word = w;
    exp_q.push_back(e);
  endtask

  function automatic exp_t mk(input string n, input logic v, input logic [6:0] msb,
                              input logic [4:0] r2, input logic [4:0] r1,
                              input logic [4:0] lsb, input logic [2:0] f3,
                              input logic [31:0] imm, input logic [1:0] size,
                              input logic st, input logic ill);
    exp_t e;
    e.name = n; e.v = v; e.msb = msb; e.rs2 = r2; e.rs1 = r1; e.lsb = lsb;
    e.f3 = f3; e.imm = imm; e.size = size; e.st = st; e.ill = ill;
    return e;
  endfunction

  // Monitor: one expected entry per rising edge once the driver has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(e.name, "out_valid",  32'(bus.out_valid),  32'(e.v));
        chk(e.name, "imm_S_MSB",  32'(bus.imm_S_MSB),  32'(e.msb));
        chk(e.name, "rs2",        32'(bus.rs2),        32'(e.rs2));
        chk(e.name, "rs1",        32'(bus.rs1),        32'(e.rs1));
        chk(e.name, "imm_S_LSB",  32'(bus.imm_S_LSB),  32'(e.lsb));
        chk(e.name, "funct3",     32'(bus.funct3),     32'(e.f3));
        chk(e.name, "imm_s",      bus.imm_s,           e.imm);
        chk(e.name, "store_size", 32'(bus.store_size), 32'(e.size));
        chk(e.name, "is_store",   32'(bus.is_store),   32'(e.st));
        chk(e.name, "illegal",    32'(bus.illegal),    32'(e.ill));
        $display("[TB] %s checked", e.name);
      end else if (bus.out_valid === 1'b1 && !driver_done) begin
        chk("unexpected", "out_valid", 32'(bus.out_valid), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid         = 1'b0;
    bus.instruction_word = '0;

    // Reset state.
    step(1, 0, 32'h0, mk("reset0", 0, 7'h00, 0, 0, 0, 0, 32'h0, 2'b11, 0, 0));
    step(1, 0, 32'h0, mk("reset1", 0, 7'h00, 0, 0, 0, 0, 32'h0, 2'b11, 0, 0));

    // Back-to-back SW decodes, then a negative offset.
    step(0, 1, 32'b0000111_00000_01101_010_11101_0100011,
         mk("sw_pos",  1, 7'h07,  0, 13, 29, 3'd2, 32'h000000FD, 2'b10, 1, 0));
    step(0, 1, 32'b0100101_10101_01100_010_01111_0100011,
         mk("sw_b2b",  1, 7'h25, 21, 12, 15, 3'd2, 32'h000004AF, 2'b10, 1, 0));
    step(0, 1, 32'b1000100_01011_00111_010_00001_0100011,
         mk("sw_neg",  1, 7'h44, 11,  7,  1, 3'd2, 32'hFFFFF881, 2'b10, 1, 0));

    // Widths.
    step(0, 1, 32'b1111111_00001_00010_000_11111_0100011,
         mk("sb",      1, 7'h7F,  1,  2, 31, 3'd0, 32'hFFFFFFFF, 2'b00, 1, 0));
    step(0, 1, 32'b0000000_11111_11111_001_00000_0100011,
         mk("sh",      1, 7'h00, 31, 31,  0, 3'd1, 32'h00000000, 2'b01, 1, 0));

    // Illegal forms: bad funct3, non-store opcodes.
    step(0, 1, 32'b0000001_00011_00100_011_00101_0100011,
         mk("f3_011",  1, 7'h01,  3,  4,  5, 3'd3, 32'h00000025, 2'b11, 0, 1));
    step(0, 1, 32'b1010101_01010_10101_111_10101_0100011,
         mk("f3_111",  1, 7'h55, 10, 21, 21, 3'd7, 32'hFFFFFAB5, 2'b11, 0, 1));
    step(0, 1, 32'b0000000_00001_00001_010_00001_0100111,
         mk("opc_bit2",1, 7'h00,  1,  1,  1, 3'd2, 32'h00000001, 2'b11, 0, 1));
    step(0, 1, 32'b0000000_00011_00010_000_00001_0110011,
         mk("rtype",   1, 7'h00,  3,  2,  1, 3'd0, 32'h00000001, 2'b11, 0, 1));

    // Valid gating: fields hold from the R-type capture, flags clear.
    step(0, 0, 32'hFFFF_FFFF,
         mk("hold0",   0, 7'h00,  3,  2,  1, 3'd0, 32'h00000001, 2'b11, 0, 0));
    step(0, 0, 32'h1234_5678,
         mk("hold1",   0, 7'h00,  3,  2,  1, 3'd0, 32'h00000001, 2'b11, 0, 0));

    // Load something, then reset with in_valid high: reset wins.
    step(0, 1, 32'b0100101_10101_01100_010_01111_0100011,
         mk("pre_rst", 1, 7'h25, 21, 12, 15, 3'd2, 32'h000004AF, 2'b10, 1, 0));
    step(1, 1, 32'b0000111_00000_01101_010_11101_0100011,
         mk("mid_rst", 0, 7'h00,  0,  0,  0, 3'd0, 32'h00000000, 2'b11, 0, 0));

    // Decode resumes with one cycle of latency.
    step(0, 1, 32'b1000100_01011_00111_010_00001_0100011,
         mk("post_rst",1, 7'h44, 11,  7,  1, 3'd2, 32'hFFFFF881, 2'b10, 1, 0));
    step(0, 0, 32'h0,
         mk("idle",    0, 7'h44, 11,  7,  1, 3'd2, 32'hFFFFF881, 2'b11, 0, 0));

    // Drain: bounded wait for the monitor to consume everything.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    driver_done = 1'b1;
    chk("drain", "queue_left", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inst_s_decoder.md
# inst_s_decoder

Registered field decoder for RISC-V S-type (store) instructions. It splits a 32-bit instruction word into the S-format fields (imm[11:5], rs2, rs1, imm[4:0]) and also provides:
- the sign-extended 32-bit store offset,
- the store width,
- store/illegal qualification flags.

It sits in the decode stage between instruction fetch and the register-file read / address-generation logic, and has one cycle of latency.

## Interface
Parameters:
- XLEN, 32, width of the sign-extended immediate output.

Ports:
- clk  input  1  rising-edge clock; one clock, all state on it.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  instruction_word is valid this cycle.
- instruction_word  input  32  instruction to decode.
- out_valid  output  1  registered in_valid.
- imm_S_MSB  output  7  instruction_word[31:25].
- rs2  output  5  instruction_word[24:20].
- rs1  output  5  instruction_word[19:15].
- imm_S_LSB  output  5  instruction_word[11:7].
- funct3  output  3  instruction_word[14:12].
- imm_s  output  XLEN  {imm_S_MSB, imm_S_LSB} sign-extended from bit 11.
- store_size  output  2  00 = byte (SB), 01 = half (SH), 10 = word (SW), 11 = none.
- is_store  output  1  opcode == 7'b0100011 and funct3 ∈ {000, 001, 010}.
- illegal  output  1  in_valid capture whose opcode ≠ 0100011 or whose funct3 ∈ {011..111}.

## Operation
- All outputs are registers updated on the rising edge of clk.
- Field outputs (imm_S_MSB, rs2, rs1, imm_S_LSB, funct3, imm_s) are captured whenever in_valid = 1, regardless of the opcode. When in_valid = 0 they hold their previous values.
- imm_s[11:0] = {instr[31:25], instr[11:7]}; imm_s[XLEN-1:12] = instr[31].
- is_store and store_size:
  - is_store = 1 only for opcode 0100011 with a legal funct3.
  - store_size equals funct3[1:0] when is_store = 1, otherwise 11.
- illegal = in_valid & ~is_store_comb. is_store and illegal are never both 1.
- out_valid <= in_valid every cycle.
- When in_valid = 0, out_valid, is_store and illegal are cleared on the next edge.
- Decode is purely positional. rs1/rs2 = x0 is legal. No checks are made on bits [6:0] beyond the opcode comparison.

## Timing
- Latency: 1 cycle. The input sampled at edge N appears on the outputs after edge N.
- Throughput: one instruction per cycle. There is no backpressure and no stall input.
- Reset (rst = 1 at an edge) clears every output to 0, except store_size, which resets to 11. rst has priority over in_valid.
- Reset asserted mid-stream drops the in-flight instruction. The first valid output after reset release appears one cycle after the first in_valid sampled with rst = 0.
- Back-to-back valid instructions update the outputs on consecutive cycles.

## Test plan
- Decode of 0000111_00000_01101_010_11101_0100011 with in_valid = 1, one cycle later:
  - imm_S_MSB = 0x07, rs2 = 0, rs1 = 13, imm_S_LSB = 29, funct3 = 2;
  - imm_s = 0x000000FD, store_size = 10, is_store = 1, illegal = 0, out_valid = 1.
- Back-to-back follow-up with 0100101_10101_01100_010_01111_0100011:
  - imm_S_MSB = 0x25, rs2 = 21, rs1 = 12, imm_S_LSB = 15;
  - imm_s = 0x000004AF (1199), is_store = 1.
- Negative offset with 1000100_01011_00111_010_00001_0100011:
  - imm_S_MSB = 0x44, rs2 = 11, rs1 = 7, imm_S_LSB = 1;
  - imm_s = 0xFFFFF881 (−1919).
- Width and illegal cases:
  - funct3 = 000 / 001 with opcode 0100011 -> store_size = 00 / 01.
  - funct3 = 011 -> illegal = 1, is_store = 0, store_size = 11, fields still decoded.
  - opcode 0110011 (R-type) -> illegal = 1.
- Valid gating: drive in_valid = 0 with a changed instruction_word -> field outputs hold, out_valid = 0, is_store = 0, illegal = 0.
- Reset: assert rst for one edge while in_valid = 1 -> all outputs 0, store_size = 11. Deasserting rst resumes decode with 1-cycle latency.
